// File: rtl/approx_add_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : approx_add_pipe_if -- operand/result handshake bundle for approx_add_pipe
// Rev    : 1.0
// ============================================================================
interface approx_add_pipe_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         approx_en;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;

  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, sum
  );
endinterface
`default_nettype wire

// File: rtl/approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module : approx_add_pipe -- two-stage lower-part-OR (LOA) adder, valid/ready in and out
//          Optional macro APPROX_ERR_STAT_EN adds error-count / max-error statistics.
// Rev    : 1.0
// ============================================================================
module approx_add_pipe #(
  parameter int W = 8,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst,
  approx_add_pipe_if.slave bus
`ifdef APPROX_ERR_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      err_cnt,
  output logic [W:0]       err_max
`endif
);

  localparam logic [63:0] C_ONE      = 64'd1;
  localparam logic [63:0] C_LO_MASK64 = (C_ONE << K) - C_ONE;
  localparam logic [63:0] C_TOP_MASK64 = (C_ONE << K) >> 1;
  localparam logic [W:0]  C_LO_MASK  = C_LO_MASK64[W:0];
  localparam logic [W:0]  C_TOP_MASK = C_TOP_MASK64[W:0];

  // Handshake
  logic s2_adv;
  logic s1_move;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  // Stage 1 combinational
  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] a_lo;
  logic [W:0] b_lo;
  logic [W:0] lo_exact;
  logic       carry_approx;

  // Stage 2 combinational
  logic [W:0] hi_sum;

  // Pipeline state
  logic       s1_valid_q, s1_valid_d;
  logic [W:0] s1_low_q,   s1_low_d;
  logic       s1_carry_q, s1_carry_d;
  logic [W:0] s1_a_hi_q,  s1_a_hi_d;
  logic [W:0] s1_b_hi_q,  s1_b_hi_d;
  logic       s2_valid_q, s2_valid_d;
  logic [W:0] sum_q,      sum_d;

`ifdef APPROX_ERR_STAT_EN
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  logic [W:0]   exact_q, exact_d;
  logic [31:0]  err_cnt_q, err_cnt_d;
  logic [W:0]   err_max_q, err_max_d;
  logic [W:0]   err_abs;
`endif

  always_comb begin
    // A stage moves forward when it is empty or its successor moves.
    s2_adv   = !s2_valid_q || bus.out_ready;
    s1_move  = s1_valid_q && s2_adv;
    in_ready = !rst && (!s1_valid_q || s1_move);
    in_fire  = bus.in_valid && in_ready;
    out_fire = s2_valid_q && bus.out_ready;

    a_ext        = {1'b0, bus.a};
    b_ext        = {1'b0, bus.b};
    a_lo         = a_ext & C_LO_MASK;
    b_lo         = b_ext & C_LO_MASK;
    lo_exact     = a_lo + b_lo;
    carry_approx = |(a_ext & b_ext & C_TOP_MASK);

    s1_valid_d = s1_valid_q;
    s1_low_d   = s1_low_q;
    s1_carry_d = s1_carry_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      // Exact mode keeps the true low sum and its carry, so stage 2 is shared by both modes.
      s1_low_d   = bus.approx_en ? (a_lo | b_lo) : (lo_exact & C_LO_MASK);
      s1_carry_d = bus.approx_en ? carry_approx : lo_exact[K];
      s1_a_hi_d  = a_ext >> K;
      s1_b_hi_d  = b_ext >> K;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    hi_sum = s1_a_hi_q + s1_b_hi_q + {{W{1'b0}}, s1_carry_q};

    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      sum_d      = (hi_sum << K) | s1_low_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

`ifdef APPROX_ERR_STAT_EN
  always_comb begin
    s1_a_d  = in_fire ? bus.a : s1_a_q;
    s1_b_d  = in_fire ? bus.b : s1_b_q;
    exact_d = s1_move ? ({1'b0, s1_a_q} + {1'b0, s1_b_q}) : exact_q;

    err_abs   = (exact_q >= sum_q) ? (exact_q - sum_q) : (sum_q - exact_q);
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (stat_clr) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (out_fire && (err_abs != '0)) begin
      if (err_cnt_q != 32'hFFFF_FFFF) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
      if (err_abs > err_max_q) begin
        err_max_d = err_abs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      exact_q   <= '0;
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      exact_q   <= exact_d;
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_low_q   <= '0;
      s1_carry_q <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_low_q   <= s1_low_d;
      s1_carry_q <= s1_carry_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_b_hi_q  <= s1_b_hi_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_approx_add_pipe -- directed self-checking bench (K=4 and K=0 instances)
// Rev    : 1.0
// ============================================================================
module tb_approx_add_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  approx_add_pipe_if #(.W(8)) bus  ();
  approx_add_pipe_if #(.W(8)) bus0 ();

`ifdef APPROX_ERR_STAT_EN
  logic        stat_clr;
  logic [31:0] err_cnt;
  logic [31:0] err_cnt0;
  logic [8:0]  err_max;
  logic [8:0]  err_max0;
`endif

  approx_add_pipe #(.W(8), .K(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef APPROX_ERR_STAT_EN
    ,
    .stat_clr (stat_clr),
    .err_cnt  (err_cnt),
    .err_max  (err_max)
`endif
  );

  approx_add_pipe #(.W(8), .K(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus0)
`ifdef APPROX_ERR_STAT_EN
    ,
    .stat_clr (stat_clr),
    .err_cnt  (err_cnt0),
    .err_max  (err_max0)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.approx_en = 1'b0;  bus.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.approx_en = 1'b0; bus0.out_ready = 1'b0;
`ifdef APPROX_ERR_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.sum !== 9'h000) begin errors++; $display("FAIL reset_sum: got %h expected 000", bus.sum); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_approx_vectors();
    logic [7:0] va [6] = '{8'h0F, 8'h08, 8'h08, 8'hFF, 8'hFF, 8'h35};
    logic [7:0] vb [6] = '{8'h01, 8'h08, 8'h08, 8'hFF, 8'hFF, 8'h4A};
    logic       vm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] ve [6] = '{9'h00F, 9'h018, 9'h010, 9'h1FF, 9'h1FE, 9'h07F};
`ifdef APPROX_ERR_STAT_EN
    logic [31:0] ecnt [6] = '{32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3};
    logic [8:0]  emax [6] = '{9'd1, 9'd8, 9'd8, 9'd8, 9'd8, 9'd8};
`endif
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.a = va[i]; bus.b = vb[i]; bus.approx_en = vm[i]; bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid: got %b expected 0", i, bus.out_valid); end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== ve[i]) begin
        errors++; $display("FAIL vec%0d_sum: got valid=%b sum=%h expected valid=1 sum=%h", i, bus.out_valid, bus.sum, ve[i]);
      end
      @(posedge clk); #1;
`ifdef APPROX_ERR_STAT_EN
      checks++;
      if (err_cnt !== ecnt[i] || err_max !== emax[i]) begin
        errors++; $display("FAIL vec%0d_stats: got cnt=%0d max=%0d expected cnt=%0d max=%0d", i, err_cnt, err_max, ecnt[i], emax[i]);
      end
`endif
    end
`ifdef APPROX_ERR_STAT_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    checks++;
    if (err_cnt !== 32'd0 || err_max !== 9'd0) begin
      errors++; $display("FAIL stat_clr: got cnt=%0d max=%0d expected 0 0", err_cnt, err_max);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'h0F, 8'h08, 8'hFF, 8'hFF};
    logic [7:0] vb [4] = '{8'h01, 8'h08, 8'hFF, 8'hFF};
    logic       vm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [8:0] ve [4] = '{9'h00F, 9'h010, 9'h1FF, 9'h1FE};
    int sent = 0, got = 0, held = 0, cyc = 0;
    logic rdy;
    while (got < 4 && cyc < 40) begin
      if (sent < 4) begin
        bus.in_valid = 1'b1; bus.a = va[sent]; bus.b = vb[sent]; bus.approx_en = vm[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      rdy = (held >= 3);
      bus.out_ready = rdy;
      #1;
      if (sent - got == 2) begin
        checks++;
        if (bus.in_ready !== rdy) begin errors++; $display("FAIL b2b_full_in_ready: got %b expected %b", bus.in_ready, rdy); end
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.sum !== ve[got]) begin errors++; $display("FAIL b2b_sum%0d: got %h expected %h", got, bus.sum, ve[got]); end
        if (rdy) got++;
        else     held++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_delivered: got %0d expected 4", got); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.approx_en = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h0F; bus.b = 8'h01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 9'h1FF) begin
      errors++; $display("FAIL stall_fill: got valid=%b sum=%h expected valid=1 sum=1ff", bus.out_valid, bus.sum);
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 9'h000) begin
      errors++; $display("FAIL mid_reset_out: got valid=%b sum=%h expected valid=0 sum=000", bus.out_valid, bus.sum);
    end
`ifdef APPROX_ERR_STAT_EN
    checks++;
    if (err_cnt !== 32'd0 || err_max !== 9'd0) begin
      errors++; $display("FAIL mid_reset_stats: got cnt=%0d max=%0d expected 0 0", err_cnt, err_max);
    end
`endif
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stale_after_reset%0d: got valid=%b sum=%h expected valid=0", i, bus.out_valid, bus.sum); end
    end
  endtask

  task automatic test_exact_k0();
    logic [7:0] va [9];
    logic [7:0] vb [9];
    logic       vm [9];
    logic [8:0] ve [9];
    int sent = 0, got = 0, cyc = 0;
    va[0] = 8'hFF; vb[0] = 8'h01; vm[0] = 1'b1; ve[0] = 9'h100;
    va[1] = 8'h0F; vb[1] = 8'h01; vm[1] = 1'b1; ve[1] = 9'h010;
    va[2] = 8'hAA; vb[2] = 8'h55; vm[2] = 1'b0; ve[2] = 9'h0FF;
    va[3] = 8'h80; vb[3] = 8'h80; vm[3] = 1'b1; ve[3] = 9'h100;
    va[4] = 8'h7F; vb[4] = 8'h7F; vm[4] = 1'b1; ve[4] = 9'h0FE;
    for (int i = 5; i < 9; i++) begin
      va[i] = 8'($urandom_range(255));
      vb[i] = 8'($urandom_range(255));
      vm[i] = i[0];
      ve[i] = {1'b0, va[i]} + {1'b0, vb[i]};
    end
    bus0.out_ready = 1'b1;
    while (got < 9 && cyc < 40) begin
      if (sent < 9) begin
        bus0.in_valid = 1'b1; bus0.a = va[sent]; bus0.b = vb[sent]; bus0.approx_en = vm[sent];
      end else begin
        bus0.in_valid = 1'b0;
      end
      #1;
      if (bus0.out_valid === 1'b1) begin
        checks++;
        if (bus0.sum !== ve[got]) begin errors++; $display("FAIL k0_sum%0d: got %h expected %h", got, bus0.sum, ve[got]); end
        got++;
      end
      if (bus0.in_valid && bus0.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bus0.in_valid = 1'b0;
    checks++; if (got != 9) begin errors++; $display("FAIL k0_delivered: got %0d expected 9", got); end
`ifdef APPROX_ERR_STAT_EN
    checks++; if (err_cnt0 !== 32'd0) begin errors++; $display("FAIL k0_err_cnt: got %0d expected 0", err_cnt0); end
`endif
  endtask

  initial begin
    test_reset();
    test_approx_vectors();
    test_back_to_back();
    test_reset_mid_stall();
    test_exact_k0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
